// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;

    function automatic int rf_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one flop per architectural register, flush > set > write-clear.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = rf_aw(NREGS_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREGS-1:0] clr_vec,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q & ~clr_vec;
        // A newly issued producer supersedes the one retiring this cycle.
        if (sb_set) begin
            busy_d[sb_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard and optional write-to-read bypass.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic                flush,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] busy;
    logic [NWR-1:0]   wr_live;
    logic [AW-1:0]    wa [NWR];
    logic [XLEN-1:0]  wd [NWR];

    for (genvar w = 0; w < NWR; w++) begin : g_wr
        assign wa[w]      = wr_addr[w*AW +: AW];
        assign wd[w]      = wr_data[w*XLEN +: XLEN];
        assign wr_live[w] = wr_en[w] && (wa[w] != ZERO_A);
    end

    // Ascending port order lets the highest-index writer win a shared address.
    always_comb begin
        regs_d  = regs_q;
        clr_vec = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_live[w]) begin
                regs_d[wa[w]]  = wd[w];
                clr_vec[wa[w]] = 1'b1;
            end
        end
        regs_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .clr_vec (clr_vec),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .flush   (flush),
        .busy    (busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit;
        logic [XLEN-1:0] hit_data;
        logic            byp;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            hit      = 1'b0;
            hit_data = '0;
            for (int w = 0; w < NWR; w++) begin
                if (wr_live[w] && (wa[w] == ra)) begin
                    hit      = 1'b1;
                    hit_data = wd[w];
                end
            end
        end

        // A write in flight during reset is discarded, so it must not be forwarded either.
        assign byp = (BYPASS != 0) && hit && !rst;

        assign rd_data[i*XLEN +: XLEN] = (ra == ZERO_A) ? '0 :
                                         byp            ? hit_data : regs_q[ra];
        assign rd_busy[i] = busy[ra] && !(byp && !(sb_set && (sb_addr == ra)));
    end

    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks of regfile_mp: bypass/no-bypass instances, scoreboard precedence, reset.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 4 read ports, 2 write ports, bypass on.
    logic [19:0]  rd_addr_a = '0;
    logic [127:0] rd_data_a;
    logic [3:0]   rd_busy_a;
    logic [1:0]   wr_en_a = '0;
    logic [9:0]   wr_addr_a = '0;
    logic [63:0]  wr_data_a = '0;
    logic         sb_set_a = 1'b0;
    logic [4:0]   sb_addr_a = '0;
    logic         flush_a = 1'b0;
    logic [4:0]   dbg_addr_a = '0;
    logic [31:0]  dbg_data_a;

    // Instance B: 2 read ports, 1 write port, bypass off.
    logic [9:0]   rd_addr_b = '0;
    logic [63:0]  rd_data_b;
    logic [1:0]   rd_busy_b;
    logic [0:0]   wr_en_b = '0;
    logic [4:0]   wr_addr_b = '0;
    logic [31:0]  wr_data_b = '0;
    logic         sb_set_b = 1'b0;
    logic [4:0]   sb_addr_b = '0;
    logic         flush_b = 1'b0;
    logic [4:0]   dbg_addr_b = '0;
    logic [31:0]  dbg_data_b;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(4), .NWR(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .sb_set(sb_set_a),
        .sb_addr(sb_addr_a), .flush(flush_a), .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .sb_set(sb_set_b),
        .sb_addr(sb_addr_b), .flush(flush_b), .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        sbs;
        logic [4:0]  sba;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  dbga;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic [31:0] e_dbg;
        logic        e_b0;
        logic        e_b1;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic sbs, input logic [4:0] sba, input logic fl,
                                input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] dbga,
                                input logic [31:0] e_d0, input logic [31:0] e_d1,
                                input logic [31:0] e_dbg, input logic e_b0, input logic e_b1);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.sbs = sbs; v.sba = sba; v.fl = fl;
        v.ra0 = ra0; v.ra1 = ra1; v.dbga = dbga;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_dbg = e_dbg; v.e_b0 = e_b0; v.e_b1 = e_b1;
        return v;
    endfunction

    task automatic idle_a();
        wr_en_a = '0; wr_addr_a = '0; wr_data_a = '0;
        sb_set_a = 1'b0; sb_addr_a = '0; flush_a = 1'b0;
    endtask

    logic [31:0] exp_mr [4];

    initial begin
        //            we     wa0 wd0           wa1 wd1    sbs sba fl ra0 ra1 dbg  e_d0          e_d1   e_dbg  b0 b1
        vecs.push_back(mk(2'b01, 1, 32'h1,      0, 32'h0,  0, 0, 0, 1,  0,  1,  32'h1,        32'h0, 32'h0,  0, 0));
        vecs.push_back(mk(2'b11, 2, 32'h2,      3, 32'h3,  0, 0, 0, 2,  3,  1,  32'h2,        32'h3, 32'h1,  0, 0));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  0, 0, 0, 1,  2,  3,  32'h1,        32'h2, 32'h3,  0, 0));
        vecs.push_back(mk(2'b01, 0, 32'h1234,   0, 32'h0,  1, 0, 0, 0,  0,  0,  32'h0,        32'h0, 32'h0,  0, 0));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  0, 0, 0, 0,  0,  0,  32'h0,        32'h0, 32'h0,  0, 0));
        vecs.push_back(mk(2'b11, 3, 32'h11,     3, 32'h22, 0, 0, 0, 3,  3,  3,  32'h22,       32'h22, 32'h3, 0, 0));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  0, 0, 0, 3,  1,  3,  32'h22,       32'h1, 32'h22, 0, 0));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  1, 9, 0, 9,  0,  9,  32'h0,        32'h0, 32'h0,  0, 0));
        vecs.push_back(mk(2'b01, 9, 32'h99,     0, 32'h0,  1, 9, 0, 9,  9,  9,  32'h99,       32'h99, 32'h0, 1, 1));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  0, 0, 0, 9,  9,  9,  32'h99,       32'h99, 32'h99, 1, 1));
        vecs.push_back(mk(2'b01, 9, 32'h9A,     0, 32'h0,  0, 0, 0, 9,  9,  9,  32'h9A,       32'h9A, 32'h99, 0, 0));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  0, 0, 0, 9,  9,  9,  32'h9A,       32'h9A, 32'h9A, 0, 0));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  1, 4, 1, 4,  9,  4,  32'h0,        32'h9A, 32'h0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  0, 0, 0, 4,  9,  4,  32'h0,        32'h9A, 32'h0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  1, 4, 0, 4,  0,  4,  32'h0,        32'h0, 32'h0,  0, 0));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  0, 0, 1, 4,  0,  4,  32'h0,        32'h0, 32'h0,  1, 0));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  0, 0, 0, 4,  0,  4,  32'h0,        32'h0, 32'h0,  0, 0));
        vecs.push_back(mk(2'b10, 0, 32'h0,      4, 32'h44, 1, 4, 0, 4,  4,  4,  32'h44,       32'h44, 32'h0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 32'h0,      0, 32'h0,  0, 0, 0, 4,  4,  4,  32'h44,       32'h44, 32'h44, 1, 1));
        vecs.push_back(mk(2'b01, 4, 32'h45,     0, 32'h0,  0, 0, 0, 4,  0,  4,  32'h45,       32'h0, 32'h44, 0, 0));

        // Reset state
        #2;
        rd_addr_a = {5'd0, 5'd0, 5'd9, 5'd1}; dbg_addr_a = 5'd1;
        #1;
        check("reset_rd0", rd_data_a[31:0], 32'h0);
        check("reset_rd1", rd_data_a[63:32], 32'h0);
        check("reset_busy", {28'h0, rd_busy_a}, 32'h0);
        check("reset_dbg", dbg_data_a, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors on the bypassing instance
        foreach (vecs[k]) begin
            @(negedge clk);
            wr_en_a    = vecs[k].we;
            wr_addr_a  = {vecs[k].wa1, vecs[k].wa0};
            wr_data_a  = {vecs[k].wd1, vecs[k].wd0};
            sb_set_a   = vecs[k].sbs;
            sb_addr_a  = vecs[k].sba;
            flush_a    = vecs[k].fl;
            rd_addr_a  = {5'd0, 5'd0, vecs[k].ra1, vecs[k].ra0};
            dbg_addr_a = vecs[k].dbga;
            #1;
            check($sformatf("v%0d_rd0", k), rd_data_a[31:0], vecs[k].e_d0);
            check($sformatf("v%0d_rd1", k), rd_data_a[63:32], vecs[k].e_d1);
            check($sformatf("v%0d_dbg", k), dbg_data_a, vecs[k].e_dbg);
            check($sformatf("v%0d_busy0", k), {31'h0, rd_busy_a[0]}, {31'h0, vecs[k].e_b0});
            check($sformatf("v%0d_busy1", k), {31'h0, rd_busy_a[1]}, {31'h0, vecs[k].e_b1});
        end

        // Multi-read on all four ports after reloading x3
        @(negedge clk);
        idle_a();
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd3}; wr_data_a = {32'h0, 32'h3};
        @(negedge clk);
        idle_a();
        rd_addr_a = {5'd0, 5'd3, 5'd2, 5'd1};
        dbg_addr_a = 5'd2;
        exp_mr[0] = 32'h1; exp_mr[1] = 32'h2; exp_mr[2] = 32'h3; exp_mr[3] = 32'h0;
        #1;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("multi_rd%0d", p), rd_data_a[p*32 +: 32], exp_mr[p]);
        end
        check("multi_dbg", dbg_data_a, 32'h2);

        // Reset mid-operation
        @(negedge clk);
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd5}; wr_data_a = {32'h0, 32'hDEADBEEF};
        @(negedge clk);
        idle_a();
        sb_set_a = 1'b1; sb_addr_a = 5'd6;
        rd_addr_a = {5'd0, 5'd0, 5'd6, 5'd5}; dbg_addr_a = 5'd5;
        #1;
        check("pre_rst_x5", rd_data_a[31:0], 32'hDEADBEEF);
        @(negedge clk);
        idle_a();
        wr_en_a = 2'b01; wr_addr_a = {5'd0, 5'd5}; wr_data_a = {32'h0, 32'hCAFEF00D};
        #1;
        check("pre_rst_byp", rd_data_a[31:0], 32'hCAFEF00D);
        check("pre_rst_busy6", {31'h0, rd_busy_a[1]}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("in_rst_x5", rd_data_a[31:0], 32'h0);
        check("in_rst_busy6", {31'h0, rd_busy_a[1]}, 32'h0);
        check("in_rst_dbg", dbg_data_a, 32'h0);
        @(negedge clk);
        idle_a();
        rst = 1'b0;
        #1;
        check("post_rst_x5", rd_data_a[31:0], 32'h0);
        @(negedge clk);
        #1;
        check("post_rst_x5_b", rd_data_a[31:0], 32'h0);
        check("post_rst_busy", {28'h0, rd_busy_a}, 32'h0);

        // Non-bypassing instance: write visible only on the next cycle, busy not forced
        @(negedge clk);
        sb_set_b = 1'b1; sb_addr_b = 5'd7; rd_addr_b = {5'd0, 5'd7}; dbg_addr_b = 5'd7;
        @(negedge clk);
        sb_set_b = 1'b0;
        wr_en_b = 1'b1; wr_addr_b = 5'd7; wr_data_b = 32'hA5A5A5A5;
        #1;
        check("nobyp_same_cycle", rd_data_b[31:0], 32'h0);
        check("nobyp_busy_held", {31'h0, rd_busy_b[0]}, 32'h1);
        @(negedge clk);
        wr_en_b = 1'b0;
        #1;
        check("nobyp_next_cycle", rd_data_b[31:0], 32'hA5A5A5A5);
        check("nobyp_busy_clr", {31'h0, rd_busy_b[0]}, 32'h0);
        check("nobyp_dbg", dbg_data_b, 32'hA5A5A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
